// File: rtl/delay_scheduler.sv
// Round-robin owner of the shared 2 kHz delay counter: grant, clear, run to the latched duration, pulse done.
// Grant 1 cycle after a sampled request, done r_dur+3 cycles after it; a dropped request cancels the run.
module delay_scheduler #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 12
) (
    input  logic                   clk_2K,
    input  logic                   i_Reset,
    input  logic [N_REQ-1:0]       i_Req,
    input  logic [N_REQ*WIDTH-1:0] i_Dur,
    input  logic [WIDTH-1:0]       i_Count,
    output logic                   o_ActCounter,
    output logic                   o_RstCounter,
    output logic [N_REQ-1:0]       o_Grant,
    output logic [N_REQ-1:0]       o_Done,
    output logic                   o_Busy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [IW-1:0]     g, g_nxt;
    logic [IW-1:0]     p, p_nxt;
    logic [IW-1:0]     g_inc;
    logic [WIDTH-1:0]  r_dur, r_dur_nxt;
    logic [IW-1:0]     pick;
    logic              pick_vld;
    logic [IW-1:0]     cand;
    logic [WIDTH-1:0]  pick_dur;
    logic              req_g;
    logic [N_REQ-1:0]  grant_oh;

    assign g_inc    = (g == IW'(N_REQ - 1)) ? '0 : g + 1'b1;
    assign req_g    = i_Req[g];
    assign grant_oh = {{(N_REQ-1){1'b0}}, 1'b1} << g;

    // Walk the ring from the farthest slot back to p so the nearest set request overwrites last.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = IW'((int'(p) + i) % N_REQ);
            if (i_Req[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        pick_dur = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (pick == IW'(k)) begin
                pick_dur = i_Dur[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk_2K) begin
        if (i_Reset) begin
            state <= IDLE;
            g     <= '0;
            p     <= '0;
            r_dur <= '0;
        end else begin
            state <= state_nxt;
            g     <= g_nxt;
            p     <= p_nxt;
            r_dur <= r_dur_nxt;
        end
    end

    // Cancel is tested before completion so a drop on the final RUN cycle yields no done.
    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        p_nxt     = p;
        r_dur_nxt = r_dur;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = CLEAR;
                    g_nxt     = pick;
                    r_dur_nxt = (pick_dur == '0) ? WIDTH'(1) : pick_dur;
                end
            end
            CLEAR: begin
                if (!req_g) begin
                    state_nxt = IDLE;
                    p_nxt     = g_inc;
                end else begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!req_g) begin
                    state_nxt = IDLE;
                    p_nxt     = g_inc;
                end else if (i_Count == r_dur) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                p_nxt     = g_inc;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The counter stops itself at r_dur, which also keeps it from saturating past the maximum.
    always_comb begin
        o_RstCounter = 1'b1;
        o_ActCounter = 1'b0;
        o_Grant      = '0;
        o_Done       = '0;
        o_Busy       = (state != IDLE);
        case (state)
            CLEAR: o_Grant = grant_oh;
            RUN: begin
                o_Grant      = grant_oh;
                o_RstCounter = 1'b0;
                o_ActCounter = (i_Count != r_dur);
            end
            DONE: begin
                o_Grant = grant_oh;
                o_Done  = grant_oh;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_delay_scheduler.sv
// Bench for delay_scheduler: a behavioural 2 kHz counter closes the loop, done pulses are scored against a queue.
module tb_delay_scheduler;

    localparam int N = 4;
    localparam int W = 12;

    logic           clk_2K = 1'b0;
    logic           i_Reset;
    logic [N-1:0]   i_Req;
    logic [N*W-1:0] i_Dur;
    logic [W-1:0]   i_Count;
    logic           o_ActCounter;
    logic           o_RstCounter;
    logic [N-1:0]   o_Grant;
    logic [N-1:0]   o_Done;
    logic           o_Busy;

    always #5 clk_2K = ~clk_2K;

    delay_scheduler #(.N_REQ(N), .WIDTH(W)) dut (
        .clk_2K      (clk_2K),
        .i_Reset     (i_Reset),
        .i_Req       (i_Req),
        .i_Dur       (i_Dur),
        .i_Count     (i_Count),
        .o_ActCounter(o_ActCounter),
        .o_RstCounter(o_RstCounter),
        .o_Grant     (o_Grant),
        .o_Done      (o_Done),
        .o_Busy      (o_Busy)
    );

    // External saturating counter driven only by the scheduler's controls.
    always @(posedge clk_2K) begin
        if (o_RstCounter)
            i_Count <= '0;
        else if (o_ActCounter && i_Count != {W{1'b1}})
            i_Count <= i_Count + 1'b1;
    end

    typedef struct {
        logic [N-1:0] mask;
        int           cyc;
        int           acts;
        int           cnt;
    } exp_t;

    typedef struct {
        int idx;
        int dur;
        int lat;
        int acts;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];

    int   errors    = 0;
    int   checks    = 0;
    int   cyc       = 0;
    int   act_cnt   = 0;
    int   done_seen = 0;
    logic busy_q    = 1'b0;

    task automatic chk(string name, int actual, int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk_2K);
        #1;
        cyc++;
        if (o_Busy && !busy_q) act_cnt = 0;
        busy_q = o_Busy;
        if (o_ActCounter) act_cnt++;
        if (o_Done != '0) begin
            done_seen++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: got mask %b expected none (cycle %0d)", o_Done, cyc);
            end else begin
                e = sb.pop_front();
                chk("done_mask", int'(o_Done), int'(e.mask));
                chk("done_cycle", cyc, e.cyc);
                chk("act_cycles", act_cnt, e.acts);
                chk("count_at_done", int'(i_Count), e.cnt);
            end
        end
    endtask

    task automatic wait_done(string name, int bound);
        int start;
        start = done_seen;
        for (int i = 0; i < bound && done_seen == start; i++) tick();
        checks++;
        if (done_seen == start) begin
            errors++;
            $display("FAIL %s: got no done within %0d cycles, required one", name, bound);
        end
    endtask

    task automatic wait_count(string name, int value, int bound);
        for (int i = 0; i < bound && int'(i_Count) != value; i++) tick();
        checks++;
        if (int'(i_Count) != value) begin
            errors++;
            $display("FAIL %s: got count %0d expected %0d within %0d cycles", name, i_Count, value, bound);
        end
    endtask

    initial begin
        logic [N-1:0] m;
        int           t;

        // {requester, duration, done latency from sampling, active cycles}
        vecs[0] = '{0, 3, 6, 3};
        vecs[1] = '{1, 0, 4, 1};
        vecs[2] = '{2, 1, 4, 1};
        vecs[3] = '{3, 7, 10, 7};
        vecs[4] = '{1, 2, 5, 2};
        vecs[5] = '{0, 5, 8, 5};

        i_Reset = 1'b1;
        i_Req   = '0;
        i_Dur   = '0;
        tick();
        tick();
        chk("rst_grant", int'(o_Grant), 0);
        chk("rst_done", int'(o_Done), 0);
        chk("rst_act", int'(o_ActCounter), 0);
        chk("rst_rstcnt", int'(o_RstCounter), 1);
        chk("rst_busy", int'(o_Busy), 0);
        i_Reset = 1'b0;
        tick();

        for (int k = 0; k < 6; k++) begin
            m = '0;
            m[vecs[k].idx] = 1'b1;
            i_Dur[vecs[k].idx*W +: W] = W'(vecs[k].dur);
            i_Req = m;
            sb.push_back('{m, cyc + vecs[k].lat, vecs[k].acts, vecs[k].acts});
            tick();
            chk("vec_grant", int'(o_Grant), int'(m));
            chk("vec_clear_rst", int'(o_RstCounter), 1);
            chk("vec_busy", int'(o_Busy), 1);
            wait_done("vec_done", 40);
            i_Req = '0;
            tick();
            tick();
        end

        // Fairness from reset: all four held, duration 2, dones r_dur+4 apart.
        i_Reset = 1'b1;
        tick();
        i_Reset = 1'b0;
        i_Dur   = {N{W'(2)}};
        i_Req   = '1;
        t = cyc;
        for (int i = 0; i < 5; i++) begin
            m = '0;
            m[i % N] = 1'b1;
            sb.push_back('{m, t + 5 + 6*i, 2, 2});
        end
        for (int j = 0; j < 5; j++) wait_done("rr_done", 20);
        i_Req = '0;
        tick();
        tick();

        // Cancel: pointer now at 1, req1 runs, dropped at count 4, req2 takes over.
        i_Dur[1*W +: W] = W'(10);
        i_Dur[2*W +: W] = W'(1);
        i_Req = 4'b0110;
        tick();
        chk("cancel_grant1", int'(o_Grant), 2);
        wait_count("cancel_reach4", 4, 30);
        i_Req = 4'b0100;
        tick();
        chk("cancel_busy", int'(o_Busy), 0);
        chk("cancel_grant_idle", int'(o_Grant), 0);
        sb.push_back('{4'b0100, cyc + 4, 1, 1});
        tick();
        chk("cancel_grant2", int'(o_Grant), 4);
        wait_done("cancel_done2", 20);
        i_Req = '0;
        tick();
        tick();

        // Maximum duration: counter must stop at 4095 and completion still fires.
        i_Dur[0 +: W] = {W{1'b1}};
        i_Req = 4'b0001;
        sb.push_back('{4'b0001, cyc + 4098, 4095, 4095});
        tick();
        chk("sat_grant", int'(o_Grant), 1);
        wait_done("sat_done", 4200);
        i_Req = '0;
        tick();
        tick();

        // Reset mid-RUN: aborted run gives no done, pointer returns to 0.
        i_Dur[2*W +: W] = W'(10);
        i_Req = 4'b0100;
        tick();
        chk("mid_grant", int'(o_Grant), 4);
        wait_count("mid_reach5", 5, 30);
        i_Reset = 1'b1;
        tick();
        chk("mid_rst_grant", int'(o_Grant), 0);
        chk("mid_rst_rstcnt", int'(o_RstCounter), 1);
        chk("mid_rst_act", int'(o_ActCounter), 0);
        chk("mid_rst_done", int'(o_Done), 0);
        chk("mid_rst_busy", int'(o_Busy), 0);
        i_Reset = 1'b0;
        i_Dur[0 +: W] = W'(1);
        i_Req = '1;
        t = cyc;
        tick();
        chk("post_rst_grant", int'(o_Grant), 1);
        sb.push_back('{4'b0001, t + 4, 1, 1});
        i_Req = 4'b0001;
        wait_done("post_rst_done", 20);
        i_Req = '0;
        tick();
        tick();

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
